// File: rtl/sprite_pkg.sv
// Shared types for the sprite motion controller: facing codes, motion
// states and the signed per-axis request encoding.
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCEL  = 2'b01,
        CRUISE = 2'b10
    } motion_state_t;

    // Per-axis request: -1 toward the axis minimum, +1 toward the maximum.
    typedef logic signed [1:0] axis_req_t;

    localparam axis_req_t REQ_NEG  = 2'sb11;
    localparam axis_req_t REQ_NONE = 2'sb00;
    localparam axis_req_t REQ_POS  = 2'sb01;

    // Full request vector, compared tick-to-tick to detect a change of heading.
    typedef struct packed {
        axis_req_t v;
        axis_req_t h;
    } req_vec_t;

    // Active-low button pair to axis request; both or neither pressed cancels.
    function automatic axis_req_t axis_request(input logic neg_n, input logic pos_n);
        case ({neg_n, pos_n})
            2'b01:   return REQ_NEG;
            2'b10:   return REQ_POS;
            default: return REQ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// Combinational single-axis position update. Edge behaviour is chosen at
// compile time: SPRITE_WRAP_EN defined snaps to the opposite edge, otherwise
// the coordinate saturates at the legal range.
module sprite_axis_step
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int SPD_W   = 3
) (
    input  logic [COORD_W-1:0] coord_i,
    input  axis_req_t          req_i,
    input  logic [SPD_W-1:0]   step_i,
    input  logic [COORD_W-1:0] min_i,
    input  logic [COORD_W-1:0] max_i,
    output logic [COORD_W-1:0] next_o
);

    // Signed with headroom so that neither min-step nor max+step can wrap.
    localparam int SUM_W = COORD_W + 2;

    logic signed [SUM_W-1:0] cur_s;
    logic signed [SUM_W-1:0] step_s;
    logic signed [SUM_W-1:0] min_s;
    logic signed [SUM_W-1:0] max_s;
    logic signed [SUM_W-1:0] sum_s;

    // Apply the signed step, then fold the result back into [min, max].
    always_comb begin
        cur_s  = $signed({2'b00, coord_i});
        min_s  = $signed({2'b00, min_i});
        max_s  = $signed({2'b00, max_i});
        step_s = $signed(SUM_W'(step_i));

        if (req_i == REQ_POS) begin
            sum_s = cur_s + step_s;
        end else if (req_i == REQ_NEG) begin
            sum_s = cur_s - step_s;
        end else begin
            sum_s = cur_s;
        end

`ifdef SPRITE_WRAP_EN
        if (sum_s > max_s) begin
            next_o = min_i;
        end else if (sum_s < min_s) begin
            next_o = max_i;
        end else begin
            next_o = sum_s[COORD_W-1:0];
        end
`else
        if (sum_s > max_s) begin
            next_o = max_i;
        end else if (sum_s < min_s) begin
            next_o = min_i;
        end else begin
            next_o = sum_s[COORD_W-1:0];
        end
`endif
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: four active-low buttons, motion on frame tick,
// diagonal moves, hold-to-accelerate speed ramp. Edge handling (clamp or wrap)
// is selected by the SPRITE_WRAP_EN macro inside sprite_axis_step.
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int COORD_W     = 10,
    parameter int X_MAX       = 640,
    parameter int Y_MAX       = 480,
    parameter int SPRITE_W    = 64,
    parameter int SPRITE_H    = 64,
    parameter int X_MIN       = 1,
    parameter int Y_MIN       = 0,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8,
    localparam int SPD_W      = $clog2(MAX_SPEED + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               up_n,
    input  logic               down_n,
    input  logic               left_n,
    input  logic               right_n,
    output logic [COORD_W-1:0] x_coord,
    output logic [COORD_W-1:0] y_coord,
    output logic [1:0]         direction,
    output logic [SPD_W-1:0]   speed,
    output logic               moving
);

    localparam int HC_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

    localparam logic [COORD_W-1:0] X_LO = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] X_HI = COORD_W'(X_MAX - SPRITE_W);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(Y_MAX - SPRITE_H);

    motion_state_t      state_q, state_d;
    logic [SPD_W-1:0]   speed_q, speed_d;
    logic [HC_W-1:0]    hcnt_q,  hcnt_d;
    req_vec_t           req_q,   req_d;
    dir_t               dir_q,   dir_d;
    logic [COORD_W-1:0] x_q,     x_d;
    logic [COORD_W-1:0] y_q,     y_d;

    req_vec_t           req_now;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;

    // Decode the buttons into this tick's request vector.
    always_comb begin
        req_now.v = axis_request(up_n, down_n);
        req_now.h = axis_request(left_n, right_n);
    end

    // Speed ramp: restart at 1 on a new heading, step up every ACCEL_TICKS holds.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        speed_d = speed_q;
        hcnt_d  = hcnt_q;
        if (tick) begin
            if (req_now == '0) begin
                state_d = IDLE;
                speed_d = '0;
                hcnt_d  = '0;
            end else if (state_q == IDLE || req_now != req_q) begin
                state_d = (MAX_SPEED == 1) ? CRUISE : ACCEL;
                speed_d = SPD_W'(1);
                hcnt_d  = '0;
            end else if (state_q == ACCEL) begin
                if (hcnt_q == HC_W'(ACCEL_TICKS - 1)) begin
                    speed_d = speed_q + SPD_W'(1);
                    hcnt_d  = '0;
                    if (speed_d == SPD_W'(MAX_SPEED)) begin
                        state_d = CRUISE;
                    end
                end else begin
                    hcnt_d = hcnt_q + HC_W'(1);
                end
            end
        end
    end

    sprite_axis_step #(.COORD_W(COORD_W), .SPD_W(SPD_W)) u_x_step (
        .coord_i (x_q),
        .req_i   (req_now.h),
        .step_i  (speed_d),
        .min_i   (X_LO),
        .max_i   (X_HI),
        .next_o  (x_next)
    );

    sprite_axis_step #(.COORD_W(COORD_W), .SPD_W(SPD_W)) u_y_step (
        .coord_i (y_q),
        .req_i   (req_now.v),
        .step_i  (speed_d),
        .min_i   (Y_LO),
        .max_i   (Y_HI),
        .next_o  (y_next)
    );

    // Position and facing: move by the freshly computed speed; horizontal wins the facing.
    always_comb begin
        req_d = req_q;
        dir_d = dir_q;
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            req_d = req_now;
            x_d   = x_next;
            y_d   = y_next;
            if (req_now.h == REQ_POS) begin
                dir_d = DIR_RIGHT;
            end else if (req_now.h == REQ_NEG) begin
                dir_d = DIR_LEFT;
            end else if (req_now.v == REQ_NEG) begin
                dir_d = DIR_UP;
            end else if (req_now.v == REQ_POS) begin
                dir_d = DIR_DOWN;
            end
        end
    end

    // State register with synchronous reset; reset wins over a coincident tick.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            speed_q <= '0;
            hcnt_q  <= '0;
            req_q   <= '0;
            dir_q   <= DIR_DOWN;
            x_q     <= X_LO;
            y_q     <= Y_LO;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            hcnt_q  <= hcnt_d;
            req_q   <= req_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign x_coord   = x_q;
    assign y_coord   = y_q;
    assign direction = dir_q;
    assign speed     = speed_q;
    assign moving    = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl (default parameters). A small
// behavioural model pushes expected outputs to a scoreboard on every driven
// cycle; hand-derived constants are checked at the notable points.
module tb_sprite_motion_ctrl;

    localparam int COORD_W     = 10;
    localparam int X_MAX       = 640;
    localparam int Y_MAX       = 480;
    localparam int SPRITE_W    = 64;
    localparam int SPRITE_H    = 64;
    localparam int X_MIN       = 1;
    localparam int Y_MIN       = 0;
    localparam int MAX_SPEED   = 4;
    localparam int ACCEL_TICKS = 8;
    localparam int SPD_W       = $clog2(MAX_SPEED + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               tick = 1'b0;
    logic               up_n = 1'b1;
    logic               down_n = 1'b1;
    logic               left_n = 1'b1;
    logic               right_n = 1'b1;
    logic [COORD_W-1:0] x_coord;
    logic [COORD_W-1:0] y_coord;
    logic [1:0]         direction;
    logic [SPD_W-1:0]   speed;
    logic               moving;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(
        .COORD_W(COORD_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
        .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
        .X_MIN(X_MIN), .Y_MIN(Y_MIN),
        .MAX_SPEED(MAX_SPEED), .ACCEL_TICKS(ACCEL_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .up_n(up_n), .down_n(down_n), .left_n(left_n), .right_n(right_n),
        .x_coord(x_coord), .y_coord(y_coord), .direction(direction),
        .speed(speed), .moving(moving)
    );

    typedef struct {
        string tag;
        int    x;
        int    y;
        int    dir;
        int    spd;
        int    mov;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Behavioural model state
    int m_x, m_y, m_dir, m_spd, m_hcnt, m_mov, m_pv, m_ph;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fit(input int n, input int lo, input int hi);
`ifdef SPRITE_WRAP_EN
        if (n > hi) return lo;
        if (n < lo) return hi;
        return n;
`else
        if (n > hi) return hi;
        if (n < lo) return lo;
        return n;
`endif
    endfunction

    task automatic model_reset();
        m_x = X_MIN; m_y = Y_MIN; m_dir = 1; m_spd = 0;
        m_hcnt = 0; m_mov = 0; m_pv = 0; m_ph = 0;
    endtask

    task automatic model_tick(input bit u, input bit d, input bit l, input bit r);
        int v;
        int h;
        v = (u && !d) ? -1 : ((d && !u) ? 1 : 0);
        h = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
        if (v == 0 && h == 0) begin
            m_spd = 0; m_hcnt = 0; m_mov = 0;
        end else if (m_mov == 0 || v != m_pv || h != m_ph) begin
            m_spd = 1; m_hcnt = 0; m_mov = 1;
        end else if (m_spd < MAX_SPEED) begin
            if (m_hcnt == ACCEL_TICKS - 1) begin
                m_spd++; m_hcnt = 0;
            end else begin
                m_hcnt++;
            end
        end
        m_pv = v; m_ph = h;
        if (h != 0)      m_dir = (h > 0) ? 3 : 2;
        else if (v != 0) m_dir = (v < 0) ? 0 : 1;
        m_x = fit(m_x + h * m_spd, X_MIN, X_MAX - SPRITE_W);
        m_y = fit(m_y + v * m_spd, Y_MIN, Y_MAX - SPRITE_H);
    endtask

    task automatic push_model(input string tag);
        exp_t e;
        e.tag = tag; e.x = m_x; e.y = m_y; e.dir = m_dir; e.spd = m_spd; e.mov = m_mov;
        sb.push_back(e);
    endtask

    task automatic compare_dut();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".x"},   32'(x_coord),   32'(e.x));
        check({e.tag, ".y"},   32'(y_coord),   32'(e.y));
        check({e.tag, ".dir"}, 32'(direction), 32'(e.dir));
        check({e.tag, ".spd"}, 32'(speed),     32'(e.spd));
        check({e.tag, ".mov"}, 32'(moving),    32'(e.mov));
    endtask

    task automatic set_buttons(input bit u, input bit d, input bit l, input bit r);
        up_n = ~u; down_n = ~d; left_n = ~l; right_n = ~r;
    endtask

    // One-cycle tick with the given buttons pressed (1 = pressed)
    task automatic tick_step(input string tag, input bit u, input bit d, input bit l, input bit r);
        set_buttons(u, d, l, r);
        tick = 1'b1;
        model_tick(u, d, l, r);
        push_model(tag);
        @(posedge clk);
        #1;
        tick = 1'b0;
        compare_dut();
    endtask

    // Cycle without tick: buttons change, nothing may move
    task automatic idle_step(input string tag, input bit u, input bit d, input bit l, input bit r);
        set_buttons(u, d, l, r);
        tick = 1'b0;
        push_model(tag);
        @(posedge clk);
        #1;
        compare_dut();
    endtask

    task automatic do_reset(input string tag, input bit with_tick);
        reset = 1'b1;
        tick  = with_tick;
        model_reset();
        push_model(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick  = 1'b0;
        compare_dut();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset("reset", 1'b0);
        check("rst.x", 32'(x_coord), 1);
        check("rst.y", 32'(y_coord), 0);
        check("rst.dir", 32'(direction), 1);
        check("rst.spd", 32'(speed), 0);
        check("rst.mov", 32'(moving), 0);

        // Single right tap
        tick_step("tap_r", 0, 0, 0, 1);
        check("tap_r.x", 32'(x_coord), 2);
        check("tap_r.dir", 32'(direction), 3);
        check("tap_r.spd", 32'(speed), 1);
        check("tap_r.mov", 32'(moving), 1);

        // Button activity without tick is ignored
        idle_step("notick_a", 1, 0, 1, 0);
        idle_step("notick_b", 0, 1, 0, 0);
        idle_step("notick_c", 1, 1, 1, 1);
        check("notick.x", 32'(x_coord), 2);
        tick_step("release", 0, 0, 0, 0);

        // Hold right for 25 ticks from x=1
        do_reset("reset2", 1'b0);
        for (int i = 1; i <= 25; i++) begin
            tick_step("ramp", 0, 0, 0, 1);
            if (i == 8)  check("ramp8.x",  32'(x_coord), 9);
            if (i == 16) check("ramp16.x", 32'(x_coord), 25);
            if (i == 24) check("ramp24.x", 32'(x_coord), 49);
            if (i == 25) begin
                check("ramp25.x",   32'(x_coord), 53);
                check("ramp25.spd", 32'(speed), 4);
            end
        end

        // Opposing vertical buttons cancel
        for (int i = 0; i < 3; i++) tick_step("updown", 1, 1, 0, 0);
        check("updown.y",   32'(y_coord), 0);
        check("updown.spd", 32'(speed), 0);
        check("updown.mov", 32'(moving), 0);

        // Walk to (100,100) with single taps, then diagonal up-left
        while (m_x < 100) begin
            tick_step("walk_x", 0, 0, 0, 1);
            tick_step("walk_rel", 0, 0, 0, 0);
        end
        while (m_y < 100) begin
            tick_step("walk_y", 0, 1, 0, 0);
            tick_step("walk_rel", 0, 0, 0, 0);
        end
        check("walk.x", 32'(x_coord), 100);
        check("walk.y", 32'(y_coord), 100);
        tick_step("diag", 1, 0, 1, 0);
        check("diag.x",   32'(x_coord), 99);
        check("diag.y",   32'(y_coord), 99);
        check("diag.dir", 32'(direction), 2);
        tick_step("release2", 0, 0, 0, 0);

`ifdef SPRITE_WRAP_EN
        // Edges snap to the opposite side
        do_reset("reset_w", 1'b0);
        tick_step("wrap_l", 0, 0, 1, 0);
        check("wrap_l.x", 32'(x_coord), 576);
        tick_step("wrap_rel", 0, 0, 0, 0);
        tick_step("wrap_r", 0, 0, 0, 1);
        check("wrap_r.x", 32'(x_coord), 1);
        tick_step("wrap_rel", 0, 0, 0, 0);
        tick_step("wrap_u", 1, 0, 0, 0);
        check("wrap_u.y", 32'(y_coord), 416);
        tick_step("wrap_rel", 0, 0, 0, 0);
`else
        // Hold right into the edge: saturate at 576 while still moving at top speed
        for (int i = 0; i < 150; i++) tick_step("clamp", 0, 0, 0, 1);
        check("clamp.x",   32'(x_coord), 576);
        check("clamp.mov", 32'(moving), 1);
        check("clamp.spd", 32'(speed), 4);
        tick_step("clamp", 0, 0, 0, 1);
        check("clamp2.x", 32'(x_coord), 576);
        tick_step("release3", 0, 0, 0, 0);
`endif

        // Reset overrides a coincident tick while cruising
        do_reset("reset3", 1'b0);
        for (int i = 0; i < 30; i++) tick_step("cruise", 0, 0, 0, 1);
        check("cruise.spd", 32'(speed), 4);
        set_buttons(0, 0, 0, 1);
        do_reset("rst_tick", 1'b1);
        check("rst_tick.x",   32'(x_coord), 1);
        check("rst_tick.spd", 32'(speed), 0);
        check("rst_tick.mov", 32'(moving), 0);
        check("rst_tick.dir", 32'(direction), 1);

        // Heading change mid-ramp restarts at speed 1
        for (int i = 0; i < 10; i++) tick_step("midramp", 0, 0, 0, 1);
        check("midramp.spd", 32'(speed), 2);
        tick_step("turn", 0, 1, 0, 0);
        check("turn.spd", 32'(speed), 1);
        check("turn.y",   32'(y_coord), 1);
        check("turn.x",   32'(x_coord), 13);
        check("turn.dir", 32'(direction), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
